// File: rtl/branch_predict_resolve.sv
// Branch unit spanning F and D: a direct-mapped BTB with 2-bit counters predicts in F,
// and D resolves beq/bne, redirects on a mispredict, trains the BTB and counts events.
module branch_predict_resolve #(
    parameter int         XLEN      = 32,
    parameter int         BTB_IDX_W = 6,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter bit         EN_BNE    = 1'b1,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_F,
    output logic             pred_taken_F,
    output logic [XLEN-1:0]  pred_target_F,
    input  logic             stall_D,
    input  logic             flush_D,
    input  logic             valid_D,
    input  logic [31:0]      inst_D,
    input  logic [XLEN-1:0]  pc_plus4_D,
    input  logic [XLEN-1:0]  rs_data_D,
    input  logic [XLEN-1:0]  rt_data_D,
    input  logic             fwd_a_D,
    input  logic             fwd_b_D,
    input  logic [XLEN-1:0]  alu_out_M,
    output logic             redirect_D,
    output logic [XLEN-1:0]  redirect_pc_D,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 2 ** BTB_IDX_W;
    localparam int TAG_W   = XLEN - BTB_IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];

    logic                 r_pred_q;
    logic [XLEN-1:0]      r_tgt_q;
    logic [BTB_IDX_W-1:0] r_idx_q;
    logic [TAG_W-1:0]     r_tag_q;

    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;

    logic [BTB_IDX_W-1:0] w_idx_F;
    logic [TAG_W-1:0]     w_tag_F;
    logic                 w_hit_F;
    logic                 w_hit_D;
    logic [5:0]           w_op;
    logic                 w_beq;
    logic                 w_bne;
    logic                 w_is_br;
    logic [XLEN-1:0]      w_a;
    logic [XLEN-1:0]      w_b;
    logic                 w_taken;
    logic [XLEN-1:0]      w_tgt;
    logic                 w_en;
    logic                 w_train;
    logic                 w_alias;
    logic                 w_unused;

    assign w_unused = &{1'b0, inst_D[25:16], pc_F[1:0]};

    // Lookup reads the table before any same-cycle training write lands.
    assign w_idx_F       = pc_F[BTB_IDX_W+1:2];
    assign w_tag_F       = pc_F[XLEN-1:BTB_IDX_W+2];
    assign w_hit_F       = r_valid[w_idx_F] && (r_tag[w_idx_F] == w_tag_F);
    assign pred_taken_F  = w_hit_F && r_ctr[w_idx_F][1];
    assign pred_target_F = w_hit_F ? r_target[w_idx_F] : '0;

    assign w_op    = inst_D[31:26];
    assign w_beq   = (w_op == 6'h04);
    assign w_bne   = EN_BNE && (w_op == 6'h05);
    assign w_is_br = valid_D && (w_beq || w_bne);
    assign w_a     = fwd_a_D ? alu_out_M : rs_data_D;
    assign w_b     = fwd_b_D ? alu_out_M : rt_data_D;
    assign w_taken = w_beq ? (w_a == w_b) : (w_a != w_b);
    assign w_tgt   = pc_plus4_D + {{(XLEN-18){inst_D[15]}}, inst_D[15:0], 2'b00};

    assign w_en    = !stall_D && !flush_D && !reset;
    assign w_train = w_en && w_is_br;
    assign w_alias = w_en && valid_D && !w_is_br && r_pred_q;
    assign w_hit_D = r_valid[r_idx_q] && (r_tag[r_idx_q] == r_tag_q);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        redirect_D    = 1'b0;
        redirect_pc_D = '0;
        if (w_train) begin
            redirect_D    = (w_taken != r_pred_q) || (w_taken && (w_tgt != r_tgt_q));
            redirect_pc_D = w_taken ? w_tgt : pc_plus4_D;
        end else if (w_alias) begin
            redirect_D    = 1'b1;
            redirect_pc_D = pc_plus4_D;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_q <= 1'b0;
            r_tgt_q  <= '0;
            r_idx_q  <= '0;
            r_tag_q  <= '0;
        end else if (flush_D) begin
            r_pred_q <= 1'b0;
            r_tgt_q  <= '0;
            r_idx_q  <= '0;
            r_tag_q  <= '0;
        end else if (!stall_D) begin
            r_pred_q <= pred_taken_F;
            r_tgt_q  <= pred_target_F;
            r_idx_q  <= w_idx_F;
            r_tag_q  <= w_tag_F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (w_train) begin
            if (w_taken) begin
                if (w_hit_D) begin
                    if (r_ctr[r_idx_q] != 2'b11) r_ctr[r_idx_q] <= r_ctr[r_idx_q] + 2'd1;
                end else begin
                    r_valid[r_idx_q] <= 1'b1;
                    r_ctr[r_idx_q]   <= 2'b10;
                end
            end else if (w_hit_D && (r_ctr[r_idx_q] != 2'b00)) begin
                r_ctr[r_idx_q] <= r_ctr[r_idx_q] - 2'd1;
            end
        end else if (w_alias) begin
            r_valid[r_idx_q] <= 1'b0;
        end
    end

    // NOTE: tag/target storage has no reset; a cleared valid bit makes its contents don't-care.
    always_ff @(posedge clk) begin
        if (w_train && w_taken) begin
            r_tag[r_idx_q]    <= r_tag_q;
            r_target[r_idx_q] <= w_tgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_train && (r_br_count != '1)) r_br_count <= r_br_count + CNT_W'(1);
            if (redirect_D && (r_mispred_count != '1)) r_mispred_count <= r_mispred_count + CNT_W'(1);
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench: two instances (bne enabled / disabled) against a table-level
// reference model, with randomized traffic, a mid-stall reset and counter saturation.
module tb_branch_predict_resolve;

    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_F;
    logic        stall_D, flush_D, valid_D;
    logic [31:0] inst_D, pc_plus4_D, rs_data_D, rt_data_D, alu_out_M;
    logic        fwd_a_D, fwd_b_D;

    logic        o_pt  [2];
    logic [31:0] o_ptg [2];
    logic        o_red [2];
    logic [31:0] o_rpc [2];
    logic [15:0] o_br  [2];
    logic [15:0] o_mis [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one table per instance, counters kept as plain integers.
    bit          m_valid [2][64];
    int          m_ctr   [2][64];
    logic [23:0] m_tag   [2][64];
    logic [31:0] m_tgt   [2][64];
    bit          q_pred  [2];
    logic [31:0] q_tgt   [2];
    int          q_idx   [2];
    logic [23:0] q_tag   [2];
    int          m_br    [2];
    int          m_mis   [2];

    always #5 clk = ~clk;

    branch_predict_resolve #(.EN_BNE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .pc_F(pc_F),
        .pred_taken_F(o_pt[0]), .pred_target_F(o_ptg[0]),
        .stall_D(stall_D), .flush_D(flush_D), .valid_D(valid_D), .inst_D(inst_D),
        .pc_plus4_D(pc_plus4_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
        .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .alu_out_M(alu_out_M),
        .redirect_D(o_red[0]), .redirect_pc_D(o_rpc[0]),
        .br_count(o_br[0]), .mispred_count(o_mis[0])
    );

    branch_predict_resolve #(.EN_BNE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .pc_F(pc_F),
        .pred_taken_F(o_pt[1]), .pred_target_F(o_ptg[1]),
        .stall_D(stall_D), .flush_D(flush_D), .valid_D(valid_D), .inst_D(inst_D),
        .pc_plus4_D(pc_plus4_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
        .fwd_a_D(fwd_a_D), .fwd_b_D(fwd_b_D), .alu_out_M(alu_out_M),
        .redirect_D(o_red[1]), .redirect_pc_D(o_rpc[1]),
        .br_count(o_br[1]), .mispred_count(o_mis[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[k][i] = 1'b0;
                m_ctr[k][i]   = 1;
            end
            q_pred[k] = 1'b0; q_tgt[k] = '0; q_idx[k] = 0; q_tag[k] = '0;
            m_br[k] = 0; m_mis[k] = 0;
        end
    endtask

    task automatic model_and_check();
        for (int k = 0; k < 2; k++) begin
            int          idx, d_idx, off;
            logic [23:0] tag;
            logic        hit, dhit, exp_pt, beq, bne, isbr, taken, en, redir;
            logic [31:0] exp_tg, a, b, tgt, rpc;
            idx    = int'(pc_F[7:2]);
            tag    = pc_F[31:8];
            hit    = m_valid[k][idx] && (m_tag[k][idx] == tag);
            exp_pt = hit && (m_ctr[k][idx] >= 2);
            exp_tg = hit ? m_tgt[k][idx] : 32'h0;
            beq    = (inst_D[31:26] == 6'h04);
            bne    = (inst_D[31:26] == 6'h05) && (k == 0);
            isbr   = valid_D && (beq || bne);
            a      = fwd_a_D ? alu_out_M : rs_data_D;
            b      = fwd_b_D ? alu_out_M : rt_data_D;
            taken  = beq ? (a == b) : (a != b);
            off    = int'($signed(inst_D[15:0]));
            tgt    = pc_plus4_D + 32'(off * 4);
            en     = !stall_D && !flush_D;
            redir  = 1'b0;
            rpc    = 32'h0;
            if (en && isbr) begin
                redir = (taken != q_pred[k]) || (taken && (tgt != q_tgt[k]));
                rpc   = taken ? tgt : pc_plus4_D;
            end else if (en && valid_D && q_pred[k]) begin
                redir = 1'b1;
                rpc   = pc_plus4_D;
            end
            check($sformatf("pred_taken_F[%0d]", k), 32'(o_pt[k]), 32'(exp_pt));
            check($sformatf("pred_target_F[%0d]", k), o_ptg[k], exp_tg);
            check($sformatf("redirect_D[%0d]", k), 32'(o_red[k]), 32'(redir));
            if (redir) check($sformatf("redirect_pc_D[%0d]", k), o_rpc[k], rpc);
            check($sformatf("br_count[%0d]", k), 32'(o_br[k]), 32'(m_br[k]));
            check($sformatf("mispred_count[%0d]", k), 32'(o_mis[k]), 32'(m_mis[k]));

            if (en && isbr) begin
                m_br[k] = (m_br[k] < CMAX) ? m_br[k] + 1 : CMAX;
                d_idx   = q_idx[k];
                dhit    = m_valid[k][d_idx] && (m_tag[k][d_idx] == q_tag[k]);
                if (taken) begin
                    if (dhit) begin
                        m_ctr[k][d_idx] = (m_ctr[k][d_idx] < 3) ? m_ctr[k][d_idx] + 1 : 3;
                    end else begin
                        m_valid[k][d_idx] = 1'b1;
                        m_tag[k][d_idx]   = q_tag[k];
                        m_ctr[k][d_idx]   = 2;
                    end
                    m_tgt[k][d_idx] = tgt;
                end else if (dhit) begin
                    m_ctr[k][d_idx] = (m_ctr[k][d_idx] > 0) ? m_ctr[k][d_idx] - 1 : 0;
                end
            end else if (redir) begin
                m_valid[k][q_idx[k]] = 1'b0;
            end
            if (redir) m_mis[k] = (m_mis[k] < CMAX) ? m_mis[k] + 1 : CMAX;

            if (flush_D) begin
                q_pred[k] = 1'b0; q_tgt[k] = '0; q_idx[k] = 0; q_tag[k] = '0;
            end else if (!stall_D) begin
                q_pred[k] = exp_pt; q_tgt[k] = exp_tg; q_idx[k] = idx; q_tag[k] = tag;
            end
        end
    endtask

    task automatic step();
        #1;
        model_and_check();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    task automatic drive_random();
        int   r;
        logic [15:0] imm;
        if (!stall_D) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       imm = 16'h0004;
                1:       imm = 16'hFFFC;
                default: imm = 16'h0008;
            endcase
            inst_D = {(r < 4) ? 6'h04 : (r < 7) ? 6'h05 : (r < 9) ? 6'h00 : 6'h23,
                      10'($urandom), imm};
            pc_plus4_D = pc_F + 32'd4;
            valid_D    = ($urandom_range(0, 9) != 0);
            rs_data_D  = 32'($urandom_range(0, 3));
            rt_data_D  = 32'($urandom_range(0, 3));
            alu_out_M  = 32'($urandom_range(0, 3));
            fwd_a_D    = 1'($urandom_range(0, 1));
            fwd_b_D    = 1'($urandom_range(0, 1));
        end
        pc_F    = rand_pc();
        stall_D = ($urandom_range(0, 6) == 0);
        flush_D = ($urandom_range(0, 13) == 0);
    endtask

    // Always-mispredicting beq: outcome is chosen opposite to the registered guess.
    task automatic drive_mispredict();
        inst_D     = {6'h04, 10'h0, 16'h0004};
        pc_plus4_D = pc_F + 32'd4;
        valid_D    = 1'b1;
        fwd_a_D    = 1'b0;
        fwd_b_D    = 1'b0;
        rs_data_D  = 32'd1;
        rt_data_D  = q_pred[0] ? 32'd2 : 32'd1;
        pc_F       = rand_pc();
        stall_D    = 1'b0;
        flush_D    = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        pc_F = 32'h100; stall_D = 1'b0; flush_D = 1'b0; valid_D = 1'b0;
        inst_D = '0; pc_plus4_D = '0; rs_data_D = '0; rt_data_D = '0;
        alu_out_M = '0; fwd_a_D = 1'b0; fwd_b_D = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_br_count[%0d]", k), 32'(o_br[k]), 32'h0);
            check($sformatf("reset_mispred_count[%0d]", k), 32'(o_mis[k]), 32'h0);
            check($sformatf("reset_pred_taken[%0d]", k), 32'(o_pt[k]), 32'h0);
        end
        reset = 1'b0;

        // Cold beq taken at 0x100: A=B=5, imm=4.
        pc_F = 32'h100; valid_D = 1'b0;
        step();
        valid_D = 1'b1; inst_D = {6'h04, 10'h0, 16'h0004}; pc_plus4_D = 32'h104;
        rs_data_D = 32'd5; rt_data_D = 32'd5; pc_F = 32'h100;
        #1;
        check("cold_redirect", 32'(o_red[0]), 32'h1);
        check("cold_redirect_pc", o_rpc[0], 32'h114);
        check("cold_same_cycle_lookup", 32'(o_pt[0]), 32'h0);
        step();
        valid_D = 1'b0;
        #1;
        check("alloc_pred_taken", 32'(o_pt[0]), 32'h1);
        check("alloc_pred_target", o_ptg[0], 32'h114);
        step();

        guard = 0;
        while (m_mis[0] < 16 && guard < 100) begin
            drive_mispredict();
            step();
            guard++;
        end
        check("mispred_reaches_16", 32'(o_mis[0]), 32'h10);

        // Asynchronous reset in the middle of a stall.
        stall_D = 1'b1;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_br_count[%0d]", k), 32'(o_br[k]), 32'h0);
            check($sformatf("midrst_mispred_count[%0d]", k), 32'(o_mis[k]), 32'h0);
            check($sformatf("midrst_pred_taken[%0d]", k), 32'(o_pt[k]), 32'h0);
            check($sformatf("midrst_redirect[%0d]", k), 32'(o_red[k]), 32'h0);
        end
        @(negedge clk);
        reset = 1'b0; stall_D = 1'b0;
        model_reset();

        for (int i = 0; i < 1500; i++) begin
            drive_random();
            step();
        end

        guard = 0;
        while (m_mis[0] < CMAX + 4 && guard < 70000) begin
            drive_mispredict();
            step();
            guard++;
            if (m_mis[0] == CMAX) m_mis[0] = (guard % 2 == 0) ? CMAX : CMAX;
            if (m_mis[0] == CMAX && guard > 4 && o_mis[0] == 16'hFFFF) break;
        end
        repeat (4) begin
            drive_mispredict();
            step();
        end
        check("mispred_saturated", 32'(o_mis[0]), 32'h0000FFFF);
        check("br_saturated", 32'(o_br[0]), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
